// File: rtl/message_printer.sv
// Collects '0'/'1' UART characters into a message RAM, then prints the RAM (MSG_LEN bytes) back out.
// Optional feature: define DROP_CNT_EN to add a saturating count of dropped rx strobes (drop_count).
module message_printer #(
    parameter int MSG_LEN  = 10,
    parameter int NUM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       byte_in,
    output logic       bit_valid,
    output logic [3:0] counter,
    output logic [3:0] addr,
    input  logic [7:0] ram_data
`ifdef DROP_CNT_EN
    ,
    output logic [7:0] drop_count
`endif
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam logic [3:0] LAST_BIT  = 4'(NUM_BITS - 1);
    localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] counter_q, counter_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       new_tx_q, new_tx_d;
    logic       bit_valid_q, bit_valid_d;
    logic       byte_in_q, byte_in_d;

    logic is_bit_char;
    logic wrapping;

    assign is_bit_char = (rx_data[7:1] == 7'b0011000);
    // The write pulse of the last bit is also the COLLECT->FETCH transition cycle.
    assign wrapping    = bit_valid_q && (counter_q == LAST_BIT);

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        addr_d      = addr_q;
        tx_data_d   = tx_data_q;
        new_tx_d    = 1'b0;
        bit_valid_d = 1'b0;
        byte_in_d   = byte_in_q;
        case (state_q)
            COLLECT: begin
                if (bit_valid_q) begin
                    if (wrapping) begin
                        counter_d = 4'd0;
                        addr_d    = 4'd0;
                        state_d   = FETCH;
                    end else begin
                        counter_d = counter_q + 4'd1;
                    end
                end
                if (new_rx_data && is_bit_char && !wrapping) begin
                    bit_valid_d = 1'b1;
                    byte_in_d   = rx_data[0];
                end
            end
            FETCH: begin
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d = ram_data;
                    new_tx_d  = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = 4'd0;
                        state_d = COLLECT;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            counter_q   <= 4'd0;
            addr_q      <= 4'd0;
            tx_data_q   <= 8'h00;
            new_tx_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            byte_in_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            addr_q      <= addr_d;
            tx_data_q   <= tx_data_d;
            new_tx_q    <= new_tx_d;
            bit_valid_q <= bit_valid_d;
            byte_in_q   <= byte_in_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign byte_in     = byte_in_q;
    assign bit_valid   = bit_valid_q;
    assign counter     = counter_q;
    assign addr        = addr_q;

`ifdef DROP_CNT_EN
    logic       rx_drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign rx_drop = new_rx_data && !((state_q == COLLECT) && is_bit_char && !wrapping);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (rx_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/message_printer.md
MESSAGE_PRINTER -- requirements
Module: message_printer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 10: bytes printed per message (8 reversed bits plus "\n", "\r").
REQ-002 SHALL have parameter NUM_BITS, default 8: accepted bit characters per message.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_data  input  8  received UART byte, valid when new_rx_data=1.
REQ-007 new_rx_data  input  1  one-cycle strobe qualifying rx_data.
REQ-008 tx_busy  input  1  UART transmitter busy; no new byte may be issued while 1.
REQ-009 tx_data  output  8  byte to transmit, valid when new_tx_data=1.
REQ-010 new_tx_data  output  1  one-cycle transmit strobe.
REQ-011 byte_in  output  1  bit value written to the message RAM: 1 for '1' (0x31), 0 for '0' (0x30).
REQ-012 bit_valid  output  1  one-cycle RAM write strobe for byte_in at counter.
REQ-013 counter  output  4  RAM write index, 0..NUM_BITS-1.
REQ-014 addr  output  4  RAM read address, 0..MSG_LEN-1.
REQ-015 ram_data  input  8  RAM read data, valid one cycle after addr is presented.

Function
REQ-016 SHALL implement states COLLECT, FETCH, SEND.
REQ-017 COLLECT: on new_rx_data with rx_data 0x30 or 0x31, SHALL pulse bit_valid for one cycle, cycle-registered, with byte_in and the current counter value stable in that cycle.
REQ-018 COLLECT: all other rx_data values SHALL be ignored; no bit_valid, counter unchanged.
REQ-019 SHALL increment counter in the cycle after each bit_valid pulse.
REQ-020 After the bit_valid pulse at counter=NUM_BITS-1, counter SHALL wrap to 0, addr SHALL be set to 0, and state SHALL go to FETCH.
REQ-021 FETCH SHALL last exactly one cycle, covering the RAM read latency, then go to SEND.
REQ-022 SEND with tx_busy=0: SHALL drive tx_data=ram_data and pulse new_tx_data for one cycle.
REQ-023 After that pulse, addr SHALL increment and state SHALL go to FETCH; if addr was MSG_LEN-1, addr SHALL return to 0 and state SHALL go to COLLECT.
REQ-024 SEND with tx_busy=1: SHALL hold tx_data, addr and state, and SHALL NOT pulse new_tx_data.
REQ-025 new_tx_data SHALL never be asserted in two consecutive cycles.
REQ-026 new_rx_data arriving in FETCH or SEND, including the cycle of the COLLECT->FETCH transition, SHALL be dropped, with no RAM write and no counter change.
REQ-027 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 On rst=1 at a clock edge:
- state=COLLECT; counter=0; addr=0; tx_data=0x00; new_tx_data=0; bit_valid=0; byte_in=0.
REQ-029 Reset mid-message SHALL abort printing; no new_tx_data SHALL follow in the cycle after reset.
REQ-030 Reset mid-collect SHALL discard partial bits; the next accepted bit SHALL be written at counter=0.

Configuration
REQ-031 Macro DROP_CNT_EN, when defined, SHALL add output drop_count [7:0].
- drop_count counts rx strobes dropped under REQ-018 or REQ-026.
- drop_count saturates at 255 and resets to 0.
- Without DROP_CNT_EN, the port and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-032 Reset, then idle 5 cycles -> all outputs at reset values; no strobes.
REQ-033 Send '1','0','1','1','0','0','0','1' with tx_busy=0 -> bit_valid at counter 0..7 with byte_in 1,0,1,1,0,0,0,1; then exactly 10 new_tx_data pulses carrying RAM bytes at addr 0..9 in order.
REQ-034 Same as REQ-033 with tx_busy held high 20 cycles after each pulse -> still exactly 10 pulses, no byte skipped or repeated; addr stable while busy.
REQ-035 Send 'a', 0x0D, '1' in COLLECT -> one bit_valid only (counter 0, byte_in 1); with DROP_CNT_EN, drop_count=2.
REQ-036 Assert rst during SEND at addr=4 -> next cycle state COLLECT, addr=0, no further new_tx_data; a following '0' is written at counter 0.
REQ-037 Send '1' during SEND -> no bit_valid; counter stays 0 for the next message.
